// File: rtl/mask_row_feeder.sv
// rtl/mask_row_feeder.sv - feeds one FWFT pattern-FIFO mask word per pixel row while STREAM is high
module mask_row_feeder #(
  parameter int C_MASK_DES_L = 18,
  parameter int C_NUM_ROWS   = 160
) (
  input  logic                    CLKMPRE,
  input  logic                    RESET,
  input  logic                    STREAM,
  input  logic                    ENABLE,
  input  logic [C_MASK_DES_L-1:0] FIFO_DOUT,
  input  logic                    FIFO_EMPTY,
  output logic                    FIFO_RD_EN,
  output logic [C_MASK_DES_L-1:0] MASK_DATA,
  output logic [15:0]             ROW_IDX,
  output logic                    PAT_DONE,
  output logic [31:0]             PAT_CNT,
  input  logic                    ERR_CLR,
  output logic                    UNDERRUN,
  output logic                    SHORT_PAT,
  output logic                    OVERRUN
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] LAST_ROW = 16'(C_NUM_ROWS - 1);

  state_t      state;
  logic [15:0] row_cnt;
  logic        emit;
  logic        word_ok;
  logic        last_row;

  // A row is consumed only while a pattern may still accept rows.
  assign emit       = STREAM && ((state == S_IDLE) || (state == S_ROW));
  assign word_ok    = ENABLE && !FIFO_EMPTY;
  assign last_row   = (row_cnt == LAST_ROW);
  assign FIFO_RD_EN = emit && word_ok && !RESET;

  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      state     <= S_IDLE;
      row_cnt   <= 16'd0;
      MASK_DATA <= '0;
      ROW_IDX   <= 16'd0;
      PAT_DONE  <= 1'b0;
      PAT_CNT   <= 32'd0;
      UNDERRUN  <= 1'b0;
      SHORT_PAT <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      PAT_DONE <= 1'b0;

      // Clear first so that any error raised in the same cycle wins.
      if (ERR_CLR) begin
        UNDERRUN  <= 1'b0;
        SHORT_PAT <= 1'b0;
        OVERRUN   <= 1'b0;
      end

      if (emit) begin
        MASK_DATA <= word_ok ? FIFO_DOUT : '0;
        ROW_IDX   <= row_cnt;
        if (ENABLE && FIFO_EMPTY) begin
          UNDERRUN <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (STREAM) begin
            row_cnt <= row_cnt + 16'd1;
            state   <= S_ROW;
          end
        end
        S_ROW: begin
          if (!STREAM) begin
            SHORT_PAT <= 1'b1;
            row_cnt   <= 16'd0;
            state     <= S_IDLE;
          end else if (last_row) begin
            PAT_DONE <= 1'b1;
            PAT_CNT  <= PAT_CNT + 32'd1;
            row_cnt  <= 16'd0;
            state    <= S_WAIT;
          end else begin
            row_cnt <= row_cnt + 16'd1;
          end
        end
        S_WAIT: begin
          if (STREAM) begin
            OVERRUN   <= 1'b1;
            MASK_DATA <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          row_cnt <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask_row_feeder.sv
// tb/tb_mask_row_feeder.sv - randomized pattern scenarios checked against a per-pattern expectation model
module tb_mask_row_feeder;

  localparam int W = 18;
  localparam int N = 160;

  logic          CLKMPRE = 1'b0;
  logic          RESET;
  logic          STREAM;
  logic          ENABLE;
  logic [W-1:0]  FIFO_DOUT;
  logic          FIFO_EMPTY;
  logic          FIFO_RD_EN;
  logic [W-1:0]  MASK_DATA;
  logic [15:0]   ROW_IDX;
  logic          PAT_DONE;
  logic [31:0]   PAT_CNT;
  logic          ERR_CLR;
  logic          UNDERRUN;
  logic          SHORT_PAT;
  logic          OVERRUN;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W-1:0]  fifo_q[$];
  logic [W-1:0]  words[$];
  logic [31:0]   exp_pat = 32'd0;
  logic          exp_u = 1'b0;
  logic          exp_s = 1'b0;
  logic          exp_o = 1'b0;
  logic          rd_seen;
  int            n_pops;

  mask_row_feeder #(.C_MASK_DES_L(W), .C_NUM_ROWS(N)) dut (
    .CLKMPRE    (CLKMPRE),
    .RESET      (RESET),
    .STREAM     (STREAM),
    .ENABLE     (ENABLE),
    .FIFO_DOUT  (FIFO_DOUT),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RD_EN (FIFO_RD_EN),
    .MASK_DATA  (MASK_DATA),
    .ROW_IDX    (ROW_IDX),
    .PAT_DONE   (PAT_DONE),
    .PAT_CNT    (PAT_CNT),
    .ERR_CLR    (ERR_CLR),
    .UNDERRUN   (UNDERRUN),
    .SHORT_PAT  (SHORT_PAT),
    .OVERRUN    (OVERRUN)
  );

  always #5 CLKMPRE = ~CLKMPRE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bench acts as the FWFT FIFO; the head is garbage while empty.
  task automatic drive_fifo();
    FIFO_EMPTY = (fifo_q.size() == 0);
    FIFO_DOUT  = FIFO_EMPTY ? W'($urandom) : fifo_q[0];
  endtask

  task automatic cycle(input logic s, input logic clr);
    STREAM  = s;
    ERR_CLR = clr;
    drive_fifo();
    #1;
    rd_seen = FIFO_RD_EN;
    @(posedge CLKMPRE);
    if (rd_seen && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      n_pops++;
    end
    @(negedge CLKMPRE);
    ERR_CLR = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_underrun"}, {31'd0, UNDERRUN}, {31'd0, exp_u});
    chk({tag, "_short"}, {31'd0, SHORT_PAT}, {31'd0, exp_s});
    chk({tag, "_overrun"}, {31'd0, OVERRUN}, {31'd0, exp_o});
  endtask

  task automatic clear_flags();
    cycle(1'b0, 1'b1);
    exp_u = 1'b0;
    exp_s = 1'b0;
    exp_o = 1'b0;
    check_flags("clr");
  endtask

  // One pattern attempt: L stream cycles, F words preloaded, enable E, ERR_CLR pulsed at stream cycle clr_k.
  task automatic run_pattern(input int L, input int F, input logic E, input int clr_k);
    logic [W-1:0] exp_word;
    logic [W-1:0] last_word;
    int           exp_pops;
    fifo_q.delete();
    words.delete();
    for (int i = 0; i < F; i++) begin
      exp_word = W'($urandom);
      fifo_q.push_back(exp_word);
      words.push_back(exp_word);
    end
    ENABLE    = E;
    n_pops    = 0;
    last_word = MASK_DATA;
    for (int k = 0; k < L; k++) begin
      cycle(1'b1, k == clr_k);
      if (k < N) begin
        exp_word = '0;
        if (E && k < F) exp_word = words[k];
        chk("rd_en", {31'd0, rd_seen}, {31'd0, (E && k < F)});
        chk("mask_data", {14'd0, MASK_DATA}, {14'd0, exp_word});
        chk("row_idx", {16'd0, ROW_IDX}, k);
        chk("pat_done", {31'd0, PAT_DONE}, {31'd0, (k == N - 1)});
        last_word = exp_word;
      end else begin
        chk("ovr_rd_en", {31'd0, rd_seen}, 32'd0);
        chk("ovr_mask_data", {14'd0, MASK_DATA}, 32'd0);
        chk("ovr_row_idx", {16'd0, ROW_IDX}, N - 1);
        chk("ovr_pat_done", {31'd0, PAT_DONE}, 32'd0);
        last_word = '0;
      end
      if (k == clr_k) begin
        exp_u = 1'b0;
        exp_s = 1'b0;
        exp_o = 1'b0;
      end
      if (E && k >= F && k < N) exp_u = 1'b1;
      if (k >= N) exp_o = 1'b1;
    end
    cycle(1'b0, 1'b0);
    chk("gap_rd_en", {31'd0, rd_seen}, 32'd0);
    chk("gap_pat_done", {31'd0, PAT_DONE}, 32'd0);
    if (L < N) exp_s = 1'b1;
    if (L >= N) exp_pat = exp_pat + 32'd1;
    cycle(1'b0, 1'b0);
    chk("hold_mask_data", {14'd0, MASK_DATA}, {14'd0, last_word});
    chk("pat_cnt", PAT_CNT, exp_pat);
    exp_pops = (L < N) ? L : N;
    if (F < exp_pops) exp_pops = F;
    if (!E) exp_pops = 0;
    chk("pops", n_pops, exp_pops);
    check_flags("pat");
  endtask

  initial begin
    RESET      = 1'b1;
    STREAM     = 1'b0;
    ENABLE     = 1'b1;
    ERR_CLR    = 1'b0;
    FIFO_EMPTY = 1'b1;
    FIFO_DOUT  = '0;
    @(negedge CLKMPRE);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    RESET = 1'b0;
    chk("rst_mask_data", {14'd0, MASK_DATA}, 32'd0);
    chk("rst_row_idx", {16'd0, ROW_IDX}, 32'd0);
    chk("rst_pat_done", {31'd0, PAT_DONE}, 32'd0);
    chk("rst_pat_cnt", PAT_CNT, 32'd0);
    check_flags("rst");
    cycle(1'b0, 1'b0);

    run_pattern(N, N, 1'b1, -1);
    clear_flags();
    run_pattern(N, 100, 1'b1, -1);
    clear_flags();
    run_pattern(50, N, 1'b1, -1);
    run_pattern(N, N, 1'b1, -1);
    clear_flags();
    run_pattern(N + 3, N + 5, 1'b1, N + 1);
    clear_flags();
    run_pattern(N, N, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      int L;
      L = $urandom_range(1, N + 10);
      run_pattern(L, $urandom_range(0, N + 10), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? $urandom_range(0, L - 1) : -1);
    end

    fifo_q.delete();
    for (int i = 0; i < N; i++) fifo_q.push_back(W'($urandom));
    ENABLE = 1'b1;
    for (int k = 0; k <= 80; k++) cycle(1'b1, 1'b0);
    chk("pre_rst_row_idx", {16'd0, ROW_IDX}, 32'd80);
    RESET = 1'b1;
    cycle(1'b0, 1'b0);
    RESET = 1'b0;
    exp_pat = 32'd0;
    exp_u   = 1'b0;
    exp_s   = 1'b0;
    exp_o   = 1'b0;
    chk("mid_rst_mask_data", {14'd0, MASK_DATA}, 32'd0);
    chk("mid_rst_row_idx", {16'd0, ROW_IDX}, 32'd0);
    chk("mid_rst_pat_done", {31'd0, PAT_DONE}, 32'd0);
    chk("mid_rst_pat_cnt", PAT_CNT, 32'd0);
    check_flags("mid_rst");
    cycle(1'b0, 1'b0);
    run_pattern(N, N, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
